mmu_walk_arbiter: RTL and testbench

- Shares the single Sv32 page-table walker (mmu) between NUM_REQ TLB requesters (port 0 = DTLB, port 1 = ITLB by default).
- Grants one requester at a time and latches its translation request so the walker sees stable inputs for the whole walk.
- Issues the walker request, then routes the completion, fault or abort back to the owner only.
- Sits between the TLBs and mmu; satp, mxr, sum and privilege go to mmu directly, not through this block.

---
 rtl/mmu_walk_arbiter.sv | 137 +++++++++++++
 tb/tb_mmu_walk_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_walk_arbiter.sv
// Arbitrates the single Sv32 page-table walker between NUM_REQ TLB requesters.
// The owner's request is latched for the whole walk and the result goes back to the owner only.
module mmu_walk_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_request,
    input  logic [NUM_REQ-1:0][31:0]  req_virtual_address,
    input  logic [NUM_REQ-1:0]        req_rnw,
    input  logic [NUM_REQ-1:0]        req_execute,
    input  logic [NUM_REQ-1:0]        req_abort,
    output logic [NUM_REQ-1:0]        req_write_entry,
    output logic [NUM_REQ-1:0]        req_is_fault,
    output logic [19:0]               req_upper_physical_address,
    output logic                      req_superpage,
    output logic [7:0]                req_perms,
    output logic                      mmu_request,
    output logic [31:0]               mmu_virtual_address,
    output logic                      mmu_rnw,
    output logic                      mmu_execute,
    output logic                      mmu_abort,
    input  logic                      mmu_ready,
    input  logic                      mmu_write_entry,
    input  logic                      mmu_is_fault,
    input  logic [19:0]               mmu_upper_physical_address,
    input  logic                      mmu_superpage,
    input  logic [7:0]                mmu_perms
);

    localparam int unsigned OW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        ISSUE   = 4'b0010,
        WAIT    = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    state_t               state;
    logic [OW-1:0]        owner;
    logic [OW-1:0]        rr_ptr;
    logic [OW-1:0]        ptr_next;
    logic [OW-1:0]        sel_idx;
    logic [OW-1:0]        k;
    logic                 sel_found;
    logic [NUM_REQ-1:0]   owner_oh;
    logic                 in_issue;
    logic                 in_wait;
    logic                 own_abort;
    logic                 resp_ok;
    logic                 resp_flt;

    assign ptr_next = OW'((int'(owner) + 1) % int'(NUM_REQ));

    // Grant selection: rotating search from rr_ptr, or lowest index first.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        k         = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (ROUND_ROBIN != 0) begin
                k = OW'((int'(rr_ptr) + i) % int'(NUM_REQ));
            end else begin
                k = OW'(i);
            end
            if (!sel_found && req_request[k]) begin
                sel_found = 1'b1;
                sel_idx   = k;
            end
        end
    end

    // Walker handshake and zero-latency response routing; an owner abort masks the completion.
    always_comb begin
        in_issue  = (state == ISSUE);
        in_wait   = (state == WAIT);
        owner_oh  = NUM_REQ'(1) << owner;
        own_abort = req_abort[owner] & (in_issue | in_wait);
        mmu_request = in_issue & mmu_ready & ~req_abort[owner];
        mmu_abort   = own_abort;
        resp_ok   = in_wait & mmu_write_entry & ~req_abort[owner];
        resp_flt  = in_wait & mmu_is_fault & ~mmu_write_entry & ~req_abort[owner];
        req_write_entry = resp_ok  ? owner_oh : '0;
        req_is_fault    = resp_flt ? owner_oh : '0;
        req_upper_physical_address = '0;
        req_superpage              = 1'b0;
        req_perms                  = '0;
        if (resp_ok || resp_flt) begin
            req_upper_physical_address = mmu_upper_physical_address;
            req_superpage              = mmu_superpage;
            req_perms                  = mmu_perms;
        end
    end

    // Ownership FSM; the latched request stays stable from ISSUE through RELEASE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            owner               <= '0;
            rr_ptr              <= '0;
            mmu_virtual_address <= '0;
            mmu_rnw             <= 1'b0;
            mmu_execute         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        owner               <= sel_idx;
                        mmu_virtual_address <= req_virtual_address[sel_idx];
                        mmu_rnw             <= req_rnw[sel_idx];
                        mmu_execute         <= req_execute[sel_idx];
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (own_abort) begin
                        rr_ptr <= ptr_next;
                        state  <= RELEASE;
                    end else if (mmu_request) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (own_abort || mmu_write_entry || mmu_is_fault) begin
                        rr_ptr <= ptr_next;
                        state  <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_walk_arbiter.sv
// Scoreboard bench for mmu_walk_arbiter: directed walks push expected events with their cycle,
// monitors pop and compare whenever a DUT presents a request, response or abort.
module tb_mmu_walk_arbiter;

    localparam int unsigned N = 2;
    localparam logic [1:0] K_REQ = 2'd0;
    localparam logic [1:0] K_OK  = 2'd1;
    localparam logic [1:0] K_FLT = 2'd2;
    localparam logic [1:0] K_ABT = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [1:0]  port;
        logic [31:0] va;
        logic        rnw;
        logic        exe;
        logic [19:0] upa;
        logic        sp;
        logic [7:0]  perms;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t q[$];
    exp_t fq[$];

    // round-robin instance
    logic [N-1:0]       req_request, req_rnw, req_execute, req_abort;
    logic [N-1:0][31:0] req_va;
    logic [N-1:0]       req_write_entry, req_is_fault;
    logic [19:0]        req_upa;
    logic               req_sp;
    logic [7:0]         req_perms;
    logic               mmu_request, mmu_rnw, mmu_execute, mmu_abort;
    logic [31:0]        mmu_va;
    logic               mmu_ready, mmu_write_entry, mmu_is_fault, mmu_sp;
    logic [19:0]        mmu_upa;
    logic [7:0]         mmu_perms;

    // fixed-priority instance
    logic [N-1:0]       fp_req, fp_rnw, fp_exe, fp_abort;
    logic [N-1:0][31:0] fp_va;
    logic [N-1:0]       fp_we_out, fp_flt_out;
    logic [19:0]        fp_upa_out;
    logic               fp_sp_out;
    logic [7:0]         fp_perms_out;
    logic               fp_mreq, fp_mrnw, fp_mexe, fp_mabort;
    logic [31:0]        fp_mva;
    logic               fp_ready, fp_we, fp_flt, fp_sp;
    logic [19:0]        fp_upa;
    logic [7:0]         fp_perms;

    logic [68:0] outs;
    assign outs = {req_write_entry, req_is_fault, req_upa, req_sp, req_perms,
                   mmu_request, mmu_va, mmu_rnw, mmu_execute, mmu_abort};

    mmu_walk_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(1)) dut (
        .clk(clk), .rst(rst),
        .req_request(req_request), .req_virtual_address(req_va), .req_rnw(req_rnw),
        .req_execute(req_execute), .req_abort(req_abort),
        .req_write_entry(req_write_entry), .req_is_fault(req_is_fault),
        .req_upper_physical_address(req_upa), .req_superpage(req_sp), .req_perms(req_perms),
        .mmu_request(mmu_request), .mmu_virtual_address(mmu_va), .mmu_rnw(mmu_rnw),
        .mmu_execute(mmu_execute), .mmu_abort(mmu_abort), .mmu_ready(mmu_ready),
        .mmu_write_entry(mmu_write_entry), .mmu_is_fault(mmu_is_fault),
        .mmu_upper_physical_address(mmu_upa), .mmu_superpage(mmu_sp), .mmu_perms(mmu_perms)
    );

    mmu_walk_arbiter #(.NUM_REQ(N), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req_request(fp_req), .req_virtual_address(fp_va), .req_rnw(fp_rnw),
        .req_execute(fp_exe), .req_abort(fp_abort),
        .req_write_entry(fp_we_out), .req_is_fault(fp_flt_out),
        .req_upper_physical_address(fp_upa_out), .req_superpage(fp_sp_out), .req_perms(fp_perms_out),
        .mmu_request(fp_mreq), .mmu_virtual_address(fp_mva), .mmu_rnw(fp_mrnw),
        .mmu_execute(fp_mexe), .mmu_abort(fp_mabort), .mmu_ready(fp_ready),
        .mmu_write_entry(fp_we), .mmu_is_fault(fp_flt),
        .mmu_upper_physical_address(fp_upa), .mmu_superpage(fp_sp), .mmu_perms(fp_perms)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic goto(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [68:0] got, input logic [68:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic exp_req(input int which, input int unsigned c, input logic [31:0] va,
                           input logic rnw, input logic exe);
        exp_t e;
        e = '0;
        e.kind = K_REQ; e.cyc = c; e.va = va; e.rnw = rnw; e.exe = exe;
        if (which == 0) q.push_back(e); else fq.push_back(e);
    endtask

    task automatic exp_rsp(input int which, input int unsigned c, input logic [1:0] kind,
                           input logic [1:0] port, input logic [19:0] upa, input logic sp,
                           input logic [7:0] perms);
        exp_t e;
        e = '0;
        e.kind = kind; e.cyc = c; e.port = port; e.upa = upa; e.sp = sp; e.perms = perms;
        if (which == 0) q.push_back(e); else fq.push_back(e);
    endtask

    task automatic check_evt(input int which, input string nm, input exp_t a);
        exp_t e;
        bit have;
        e = '0;
        if (which == 0) begin
            have = (q.size() != 0);
            if (have) e = q.pop_front();
        end else begin
            have = (fq.size() != 0);
            if (have) e = fq.pop_front();
        end
        total++;
        if (!have || e !== a) begin
            bad++;
            $display("FAIL %s: got kind=%0d cyc=%0d port=%0d va=%h rnw=%b exe=%b upa=%h sp=%b perms=%h; expected(queued=%0b) kind=%0d cyc=%0d port=%0d va=%h rnw=%b exe=%b upa=%h sp=%b perms=%h",
                     nm, a.kind, a.cyc, a.port, a.va, a.rnw, a.exe, a.upa, a.sp, a.perms,
                     have, e.kind, e.cyc, e.port, e.va, e.rnw, e.exe, e.upa, e.sp, e.perms);
        end
    endtask

    function automatic logic [1:0] port_of(input logic [N-1:0] oh);
        if (oh == 2'b01) return 2'd0;
        if (oh == 2'b10) return 2'd1;
        return 2'd3;
    endfunction

    // monitor: round-robin instance
    always @(negedge clk) begin
        if (!rst) begin
            exp_t a;
            if (mmu_request) begin
                a = '0; a.kind = K_REQ; a.cyc = cyc; a.va = mmu_va; a.rnw = mmu_rnw; a.exe = mmu_execute;
                check_evt(0, "rr_request", a);
            end
            if ((req_write_entry | req_is_fault) != '0) begin
                a = '0;
                a.kind = (req_write_entry != '0) ? K_OK : K_FLT;
                a.cyc = cyc; a.port = port_of(req_write_entry | req_is_fault);
                a.upa = req_upa; a.sp = req_sp; a.perms = req_perms;
                check_evt(0, "rr_response", a);
            end
            if (mmu_abort) begin
                a = '0; a.kind = K_ABT; a.cyc = cyc;
                check_evt(0, "rr_abort", a);
            end
        end
    end

    // monitor: fixed-priority instance
    always @(negedge clk) begin
        if (!rst) begin
            exp_t a;
            if (fp_mreq) begin
                a = '0; a.kind = K_REQ; a.cyc = cyc; a.va = fp_mva; a.rnw = fp_mrnw; a.exe = fp_mexe;
                check_evt(1, "fp_request", a);
            end
            if ((fp_we_out | fp_flt_out) != '0) begin
                a = '0;
                a.kind = (fp_we_out != '0) ? K_OK : K_FLT;
                a.cyc = cyc; a.port = port_of(fp_we_out | fp_flt_out);
                a.upa = fp_upa_out; a.sp = fp_sp_out; a.perms = fp_perms_out;
                check_evt(1, "fp_response", a);
            end
            if (fp_mabort) begin
                a = '0; a.kind = K_ABT; a.cyc = cyc;
                check_evt(1, "fp_abort", a);
            end
        end
    end

    initial begin
        int unsigned t;
        rst = 1'b1;
        req_request = '0; req_rnw = '0; req_execute = '0; req_abort = '0; req_va = '0;
        mmu_ready = 1'b1; mmu_write_entry = 1'b0; mmu_is_fault = 1'b0;
        mmu_upa = '0; mmu_sp = 1'b0; mmu_perms = '0;
        fp_req = '0; fp_rnw = '0; fp_exe = '0; fp_abort = '0; fp_va = '0;
        fp_ready = 1'b1; fp_we = 1'b0; fp_flt = 1'b0; fp_upa = '0; fp_sp = 1'b0; fp_perms = '0;

        // reset holds every output low even with live inputs
        goto(2);
        req_request = 2'b11; req_abort = 2'b11; mmu_write_entry = 1'b1; mmu_is_fault = 1'b1;
        mmu_upa = 20'hFFFFF; mmu_perms = 8'hFF;
        @(negedge clk);
        chk("reset_outputs", outs, '0);
        goto(3);
        rst = 1'b0;
        req_request = '0; req_abort = '0; mmu_write_entry = 1'b0; mmu_is_fault = 1'b0;
        mmu_upa = '0; mmu_perms = '0;
        @(negedge clk);
        chk("post_reset_idle", outs, '0);

        // single walk on port 0, then a faulting walk on port 1 raised during RELEASE
        goto(5); t = cyc;
        exp_req(0, t + 1, 32'h8040_3123, 1'b1, 1'b0);
        exp_rsp(0, t + 6, K_OK, 2'd0, 20'h12345, 1'b0, 8'hCF);
        req_va[0] = 32'h8040_3123; req_rnw = 2'b01; req_request = 2'b01;
        goto(t + 6);
        mmu_write_entry = 1'b1; mmu_upa = 20'h12345; mmu_perms = 8'hCF;
        goto(t + 7);
        mmu_write_entry = 1'b0; mmu_upa = '0; mmu_perms = '0;
        req_request = 2'b10; req_va[1] = 32'h0000_5000; req_rnw = 2'b00; req_execute = 2'b10;
        exp_req(0, t + 9, 32'h0000_5000, 1'b0, 1'b1);
        exp_rsp(0, t + 11, K_FLT, 2'd1, 20'hABCDE, 1'b1, 8'h01);
        goto(t + 11);
        mmu_is_fault = 1'b1; mmu_upa = 20'hABCDE; mmu_sp = 1'b1; mmu_perms = 8'h01;
        goto(t + 12);
        mmu_is_fault = 1'b0; mmu_upa = '0; mmu_sp = 1'b0; mmu_perms = '0;
        req_request = '0; req_execute = '0;
        mmu_write_entry = 1'b1;
        goto(t + 13);
        mmu_write_entry = 1'b0; mmu_is_fault = 1'b1;
        goto(t + 14);
        mmu_is_fault = 1'b0;

        // round-robin contention: grants 0,1,0,1 with one RELEASE cycle between walks
        goto(t + 15); t = cyc;
        req_va[0] = 32'h1000_0AB0; req_va[1] = 32'h2000_0CD0; req_rnw = 2'b01;
        for (int k = 0; k < 4; k++) begin
            exp_req(0, t + 1 + 5 * k, (k % 2 == 0) ? 32'h1000_0AB0 : 32'h2000_0CD0,
                    (k % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            exp_rsp(0, t + 3 + 5 * k, K_OK, 2'(k % 2), 20'h00100 + 20'(k), 1'b0, 8'h0F);
        end
        req_request = 2'b11;
        for (int k = 0; k < 4; k++) begin
            goto(t + 3 + 5 * k);
            mmu_write_entry = 1'b1; mmu_upa = 20'h00100 + 20'(k); mmu_perms = 8'h0F;
            goto(t + 4 + 5 * k);
            mmu_write_entry = 1'b0; mmu_upa = '0; mmu_perms = '0;
            if (k == 3) req_request = '0;
        end

        // abort in WAIT by owner 1, then abort racing a fault on owner 0
        goto(t + 21); t = cyc;
        req_va[1] = 32'h3000_0000; req_rnw = '0; req_request = 2'b10;
        exp_req(0, t + 1, 32'h3000_0000, 1'b0, 1'b0);
        exp_abt_block: begin
            exp_t e;
            e = '0; e.kind = K_ABT; e.cyc = t + 3;
            q.push_back(e);
        end
        goto(t + 2);
        req_va[0] = 32'h4000_0040; req_request = 2'b11;
        goto(t + 3);
        req_abort = 2'b10;
        goto(t + 4);
        req_abort = '0; req_request = 2'b01;
        exp_req(0, t + 6, 32'h4000_0040, 1'b0, 1'b0);
        race_block: begin
            exp_t e;
            e = '0; e.kind = K_ABT; e.cyc = t + 8;
            q.push_back(e);
        end
        goto(t + 8);
        req_abort = 2'b01; mmu_is_fault = 1'b1; mmu_upa = 20'h55555;
        goto(t + 9);
        req_abort = '0; mmu_is_fault = 1'b0; mmu_upa = '0; req_request = '0;

        // walker stall with a non-owner abort and changing inputs on the owner port
        goto(t + 11); t = cyc;
        mmu_ready = 1'b0;
        req_va[0] = 32'h7777_0000; req_rnw = 2'b01; req_execute = 2'b01; req_request = 2'b01;
        exp_req(0, t + 5, 32'h7777_0000, 1'b1, 1'b1);
        goto(t + 2);
        req_abort = 2'b10; req_va[0] = 32'hDEAD_BEEF; req_rnw = '0; req_execute = '0;
        goto(t + 3);
        req_abort = '0;
        @(negedge clk);
        chk("stall_latched", 69'({mmu_request, mmu_va, mmu_rnw, mmu_execute}),
            69'({1'b0, 32'h7777_0000, 1'b1, 1'b1}));
        goto(t + 5);
        mmu_ready = 1'b1;
        exp_rsp(0, t + 7, K_OK, 2'd0, 20'h0BEEF, 1'b1, 8'hFF);
        goto(t + 7);
        mmu_write_entry = 1'b1; mmu_upa = 20'h0BEEF; mmu_sp = 1'b1; mmu_perms = 8'hFF;
        goto(t + 8);
        mmu_write_entry = 1'b0; mmu_upa = '0; mmu_sp = 1'b0; mmu_perms = '0; req_request = '0;

        // reset in WAIT drops the walk; the late completion must not reach the requester
        goto(t + 10); t = cyc;
        req_va[1] = 32'h0BAD_0000; req_request = 2'b10;
        exp_req(0, t + 1, 32'h0BAD_0000, 1'b0, 1'b0);
        goto(t + 3);
        rst = 1'b1;
        goto(t + 4);
        req_request = '0; mmu_write_entry = 1'b1; mmu_upa = 20'h11111; mmu_perms = 8'hFF;
        @(negedge clk);
        chk("reset_midwalk", outs, '0);
        goto(t + 5);
        rst = 1'b0;
        @(negedge clk);
        chk("after_midwalk_reset", outs, '0);
        goto(t + 6);
        mmu_write_entry = 1'b0; mmu_upa = '0; mmu_perms = '0;
        req_va[0] = 32'h0000_0A00; req_request = 2'b11;
        exp_req(0, t + 7, 32'h0000_0A00, 1'b0, 1'b0);
        exp_rsp(0, t + 8, K_OK, 2'd0, 20'h22222, 1'b0, 8'h03);
        goto(t + 8);
        mmu_write_entry = 1'b1; mmu_upa = 20'h22222; mmu_perms = 8'h03;
        goto(t + 9);
        mmu_write_entry = 1'b0; mmu_upa = '0; mmu_perms = '0; req_request = '0;

        // fixed priority: port 0 wins every time until it drops
        goto(t + 11); t = cyc;
        fp_va[0] = 32'hF000_0000; fp_va[1] = 32'hF100_0000;
        for (int k = 0; k < 3; k++) begin
            exp_req(1, t + 1 + 5 * k, 32'hF000_0000, 1'b0, 1'b0);
            exp_rsp(1, t + 3 + 5 * k, K_OK, 2'd0, 20'(k + 1), 1'b0, 8'h07);
        end
        exp_req(1, t + 16, 32'hF100_0000, 1'b0, 1'b0);
        exp_rsp(1, t + 18, K_OK, 2'd1, 20'h00009, 1'b0, 8'h07);
        fp_req = 2'b11;
        for (int k = 0; k < 3; k++) begin
            goto(t + 3 + 5 * k);
            fp_we = 1'b1; fp_upa = 20'(k + 1); fp_perms = 8'h07;
            if (k == 2) fp_req = 2'b10;
            goto(t + 4 + 5 * k);
            fp_we = 1'b0; fp_upa = '0; fp_perms = '0;
        end
        goto(t + 18);
        fp_we = 1'b1; fp_upa = 20'h00009; fp_perms = 8'h07;
        goto(t + 19);
        fp_we = 1'b0; fp_upa = '0; fp_perms = '0; fp_req = '0;

        goto(t + 22);
        chk("rr_events_outstanding", 69'(q.size()), '0);
        chk("fp_events_outstanding", 69'(fq.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
